// File: rtl/hello_scroll_ctrl.sv
// Rotation-select sequencer for the scrolling HELLO display (auto scroll, single step, load).
// Optional build macro HELLO_SCROLL_DWELL_EN pauses at rotation 0 for DWELL_TICKS scroll periods.
`timescale 1ns/1ps
module hello_scroll_ctrl #(
    parameter int TICK_DIV    = 25000000,
    parameter int DWELL_TICKS = 2
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       run,
    input  logic       dir,
    input  logic       step,
    input  logic       load,
    input  logic [2:0] load_val,
    output logic [2:0] rot_sel,
    output logic       tick,
    output logic       running
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DWELL = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] pre_cnt;
    logic [PW-1:0] pre_nxt;
    logic [2:0]    rot_nxt;
    logic [2:0]    adv_val;
    logic          tick_nxt;
    logic          running_nxt;
    logic          advance;
    logic          step_s1;
    logic          step_s2;
    logic          step_hist;
    logic          step_rise;

`ifdef HELLO_SCROLL_DWELL_EN
    localparam bit DWELL_ON = (DWELL_TICKS > 0);
    localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);

    logic [DW-1:0] dwell_cnt;
    logic [DW-1:0] dwell_nxt;
    logic          dwell_done;

    assign dwell_done = (dwell_cnt == DWELL_LAST);

    // Counts completed prescaler periods while parked in DWELL; zero anywhere else.
    always_comb begin
        dwell_nxt = '0;
        if (state == DWELL && state_nxt == DWELL) begin
            dwell_nxt = (pre_cnt == PRE_LAST) ? dwell_cnt + 1'b1 : dwell_cnt;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            dwell_cnt <= '0;
        end else begin
            dwell_cnt <= dwell_nxt;
        end
    end
`else
    // Dwell compiled out: the entry condition is constant false, so DWELL is unreachable.
    localparam bit DWELL_ON = (DWELL_TICKS < 0);
`endif

    assign step_rise = step_s2 & ~step_hist;
    assign adv_val   = dir ? (rot_sel - 3'd1) : (rot_sel + 3'd1);

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            step_s1   <= 1'b0;
            step_s2   <= 1'b0;
            step_hist <= 1'b0;
        end else begin
            step_s1   <= step;
            step_s2   <= step_s1;
            step_hist <= step_s2;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state   <= IDLE;
            pre_cnt <= '0;
            rot_sel <= 3'd0;
            tick    <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= state_nxt;
            pre_cnt <= pre_nxt;
            rot_sel <= rot_nxt;
            tick    <= tick_nxt;
            running <= running_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pre_nxt   = pre_cnt;
        rot_nxt   = rot_sel;
        tick_nxt  = 1'b0;
        advance   = 1'b0;

        case (state)
            IDLE: begin
                pre_nxt = '0;
                advance = step_rise;
                if (run) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!run) begin
                    state_nxt = IDLE;
                    pre_nxt   = '0;
                end else if (pre_cnt == PRE_LAST) begin
                    pre_nxt = '0;
                    advance = 1'b1;
                end else begin
                    pre_nxt = pre_cnt + 1'b1;
                end
            end
            DWELL: begin
`ifdef HELLO_SCROLL_DWELL_EN
                if (!run) begin
                    state_nxt = IDLE;
                    pre_nxt   = '0;
                end else if (pre_cnt == PRE_LAST) begin
                    pre_nxt = '0;
                    if (dwell_done) begin
                        state_nxt = RUN;
                    end
                end else begin
                    pre_nxt = pre_cnt + 1'b1;
                end
`else
                state_nxt = run ? RUN : IDLE;
                pre_nxt   = '0;
`endif
            end
            default: begin
                state_nxt = IDLE;
                pre_nxt   = '0;
            end
        endcase

        // A load overrides any advance in the same cycle and restarts the scroll period.
        if (load) begin
            rot_nxt = load_val;
            pre_nxt = '0;
            if (state == DWELL && run) begin
                state_nxt = RUN;
            end
        end else if (advance) begin
            rot_nxt  = adv_val;
            tick_nxt = 1'b1;
            if (state == RUN && DWELL_ON && adv_val == 3'd0) begin
                state_nxt = DWELL;
            end
        end

        running_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
// Directed self-checking bench for hello_scroll_ctrl with TICK_DIV=4, DWELL_TICKS=2.
// Inputs change and outputs are sampled 1ns after each rising clock edge.
`timescale 1ns/1ps
module tb_hello_scroll_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn   = 1'b0;
    logic       run      = 1'b0;
    logic       dir      = 1'b0;
    logic       step     = 1'b0;
    logic       load     = 1'b0;
    logic [2:0] load_val = 3'd0;
    logic [2:0] rot_sel;
    logic       tick;
    logic       running;

    bit clk_en   = 1'b1;
    int checks   = 0;
    int failures = 0;

    hello_scroll_ctrl #(
        .TICK_DIV    (4),
        .DWELL_TICKS (2)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .run      (run),
        .dir      (dir),
        .step     (step),
        .load     (load),
        .load_val (load_val),
        .rot_sel  (rot_sel),
        .tick     (tick),
        .running  (running)
    );

    always #5 if (clk_en) CLOCK_50 = ~CLOCK_50;

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic apply_reset();
        run      = 1'b0;
        dir      = 1'b0;
        load     = 1'b0;
        load_val = 3'd0;
        Resetn   = 1'b0;
        cycle(2);
        Resetn = 1'b1;
    endtask

    task automatic test_reset();
        step = 1'b0;
        apply_reset();
        checks++;
        if ({rot_sel, tick, running} !== {3'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_state: got rot=%0d tick=%0d running=%0d expected rot=0 tick=0 running=0",
                     rot_sel, tick, running);
        end
        cycle(3);
        checks++;
        if ({rot_sel, tick, running} !== {3'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_idle_hold: got rot=%0d tick=%0d running=%0d expected rot=0 tick=0 running=0",
                     rot_sel, tick, running);
        end
    endtask

    task automatic test_scroll_up();
        apply_reset();
        dir = 1'b0;
        run = 1'b1;
        cycle(1);
        checks++;
        if ({rot_sel, tick, running} !== {3'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL up_enter_run: got rot=%0d tick=%0d running=%0d expected rot=0 tick=0 running=1",
                     rot_sel, tick, running);
        end
        for (int v = 1; v <= 8; v++) begin
            for (int k = 0; k < 3; k++) begin
                cycle(1);
                checks++;
                if ({rot_sel, tick} !== {3'(v - 1), 1'b0}) begin
                    failures++;
                    $display("[TB] FAIL up_hold v=%0d: got rot=%0d tick=%0d expected rot=%0d tick=0",
                             v, rot_sel, tick, v - 1);
                end
            end
            cycle(1);
            checks++;
            if ({rot_sel, tick, running} !== {3'(v), 1'b1, 1'b1}) begin
                failures++;
                $display("[TB] FAIL up_advance v=%0d: got rot=%0d tick=%0d running=%0d expected rot=%0d tick=1 running=1",
                         v, rot_sel, tick, running, v % 8);
            end
        end
        run = 1'b0;
    endtask

    task automatic test_scroll_down();
        apply_reset();
        dir = 1'b1;
        run = 1'b1;
        cycle(5);
        checks++;
        if ({rot_sel, tick} !== {3'd7, 1'b1}) begin
            failures++;
            $display("[TB] FAIL down_wrap: got rot=%0d tick=%0d expected rot=7 tick=1", rot_sel, tick);
        end
        cycle(3);
        checks++;
        if ({rot_sel, tick} !== {3'd7, 1'b0}) begin
            failures++;
            $display("[TB] FAIL down_hold: got rot=%0d tick=%0d expected rot=7 tick=0", rot_sel, tick);
        end
        cycle(1);
        checks++;
        if ({rot_sel, tick} !== {3'd6, 1'b1}) begin
            failures++;
            $display("[TB] FAIL down_second: got rot=%0d tick=%0d expected rot=6 tick=1", rot_sel, tick);
        end
        // Direction flips mid-period; only its value at the advancing edge matters.
        cycle(2);
        dir = 1'b0;
        cycle(2);
        checks++;
        if ({rot_sel, tick} !== {3'd7, 1'b1}) begin
            failures++;
            $display("[TB] FAIL dir_sample: got rot=%0d tick=%0d expected rot=7 tick=1", rot_sel, tick);
        end
        run = 1'b0;
    endtask

    task automatic test_step();
        int tick_count;
        apply_reset();
        load     = 1'b1;
        load_val = 3'd2;
        cycle(1);
        load = 1'b0;
        checks++;
        if ({rot_sel, tick, running} !== {3'd2, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL step_preload: got rot=%0d tick=%0d running=%0d expected rot=2 tick=0 running=0",
                     rot_sel, tick, running);
        end
        step = 1'b1;
        tick_count = 0;
        cycle(2);
        checks++;
        if ({rot_sel, tick} !== {3'd2, 1'b0}) begin
            failures++;
            $display("[TB] FAIL step_latency: got rot=%0d tick=%0d expected rot=2 tick=0", rot_sel, tick);
        end
        cycle(1);
        checks++;
        if ({rot_sel, tick} !== {3'd3, 1'b1}) begin
            failures++;
            $display("[TB] FAIL step_third_edge: got rot=%0d tick=%0d expected rot=3 tick=1", rot_sel, tick);
        end
        tick_count += int'(tick);
        for (int k = 0; k < 6; k++) begin
            if (k == 2) step = 1'b0;
            cycle(1);
            tick_count += int'(tick);
        end
        checks++;
        if (rot_sel !== 3'd3 || tick_count != 1) begin
            failures++;
            $display("[TB] FAIL step_single: got rot=%0d ticks=%0d expected rot=3 ticks=1", rot_sel, tick_count);
        end
    endtask

    task automatic test_step_in_run();
        apply_reset();
        run = 1'b1;
        cycle(1);
        step = 1'b1;
        cycle(3);
        checks++;
        if ({rot_sel, tick} !== {3'd0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL step_ignored_run: got rot=%0d tick=%0d expected rot=0 tick=0", rot_sel, tick);
        end
        cycle(1);
        checks++;
        if ({rot_sel, tick} !== {3'd1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL step_run_auto: got rot=%0d tick=%0d expected rot=1 tick=1", rot_sel, tick);
        end
        step = 1'b0;
        run  = 1'b0;
    endtask

    task automatic test_reset_step();
        step = 1'b1;
        apply_reset();
        cycle(2);
        checks++;
        if ({rot_sel, tick} !== {3'd0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL rst_step_early: got rot=%0d tick=%0d expected rot=0 tick=0", rot_sel, tick);
        end
        cycle(1);
        checks++;
        if ({rot_sel, tick} !== {3'd1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL rst_step_advance: got rot=%0d tick=%0d expected rot=1 tick=1", rot_sel, tick);
        end
        cycle(4);
        checks++;
        if ({rot_sel, tick} !== {3'd1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL rst_step_once: got rot=%0d tick=%0d expected rot=1 tick=0", rot_sel, tick);
        end
        step = 1'b0;
        cycle(3);
    endtask

    task automatic test_load_terminal();
        apply_reset();
        run = 1'b1;
        cycle(4);
        load     = 1'b1;
        load_val = 3'd5;
        cycle(1);
        load = 1'b0;
        checks++;
        if ({rot_sel, tick, running} !== {3'd5, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL load_priority: got rot=%0d tick=%0d running=%0d expected rot=5 tick=0 running=1",
                     rot_sel, tick, running);
        end
        cycle(3);
        checks++;
        if ({rot_sel, tick} !== {3'd5, 1'b0}) begin
            failures++;
            $display("[TB] FAIL load_hold: got rot=%0d tick=%0d expected rot=5 tick=0", rot_sel, tick);
        end
        cycle(1);
        checks++;
        if ({rot_sel, tick} !== {3'd6, 1'b1}) begin
            failures++;
            $display("[TB] FAIL load_next: got rot=%0d tick=%0d expected rot=6 tick=1", rot_sel, tick);
        end
        run = 1'b0;
    endtask

    task automatic test_stop_terminal();
        apply_reset();
        run = 1'b1;
        cycle(4);
        run = 1'b0;
        cycle(1);
        checks++;
        if ({rot_sel, tick, running} !== {3'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL stop_suppress: got rot=%0d tick=%0d running=%0d expected rot=0 tick=0 running=0",
                     rot_sel, tick, running);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        run = 1'b1;
        cycle(13);
        checks++;
        if ({rot_sel, tick, running} !== {3'd3, 1'b1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL arst_setup: got rot=%0d tick=%0d running=%0d expected rot=3 tick=1 running=1",
                     rot_sel, tick, running);
        end
        clk_en = 1'b0;
        #2;
        Resetn = 1'b0;
        #2;
        checks++;
        if ({rot_sel, tick, running} !== {3'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL arst_immediate: got rot=%0d tick=%0d running=%0d expected rot=0 tick=0 running=0",
                     rot_sel, tick, running);
        end
        run    = 1'b0;
        clk_en = 1'b1;
        cycle(2);
        Resetn = 1'b1;
    endtask

    task automatic test_wrap_dwell();
        apply_reset();
        load     = 1'b1;
        load_val = 3'd7;
        cycle(1);
        load = 1'b0;
        run  = 1'b1;
        cycle(5);
        checks++;
        if ({rot_sel, tick, running} !== {3'd0, 1'b1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL wrap_to_zero: got rot=%0d tick=%0d running=%0d expected rot=0 tick=1 running=1",
                     rot_sel, tick, running);
        end
`ifdef HELLO_SCROLL_DWELL_EN
        for (int k = 1; k < 12; k++) begin
`else
        for (int k = 1; k < 4; k++) begin
`endif
            cycle(1);
            checks++;
            if ({rot_sel, tick, running} !== {3'd0, 1'b0, 1'b1}) begin
                failures++;
                $display("[TB] FAIL zero_hold k=%0d: got rot=%0d tick=%0d running=%0d expected rot=0 tick=0 running=1",
                         k, rot_sel, tick, running);
            end
        end
        cycle(1);
        checks++;
        if ({rot_sel, tick} !== {3'd1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL zero_leave: got rot=%0d tick=%0d expected rot=1 tick=1", rot_sel, tick);
        end
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scroll_up();
        test_scroll_down();
        test_step();
        test_step_in_run();
        test_reset_step();
        test_load_terminal();
        test_stop_terminal();
        test_async_reset();
        test_wrap_dwell();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hello_scroll_ctrl.md
HELLO_SCROLL_CTRL -- requirements
Module: hello_scroll_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000, clock cycles per automatic scroll step (legal range >= 2).
REQ-002 SHALL have parameter DWELL_TICKS, default 2, extra scroll periods held at rotation 0 (used only with HELLO_SCROLL_DWELL_EN).
REQ-003 SHALL have port CLOCK_50  in  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have port Resetn  in  1  asynchronous active-low reset.
REQ-005 SHALL have port run  in  1  level; 1 = automatic scrolling, 0 = stopped.
REQ-006 SHALL have port dir  in  1  0 = rotation increments, 1 = rotation decrements.
REQ-007 SHALL have port step  in  1  asynchronous pushbutton level, active-high; single-step request while stopped.
REQ-008 SHALL have port load  in  1  synchronous load strobe for rotation value.
REQ-009 SHALL have port load_val  in  3  rotation value loaded when load=1.
REQ-010 SHALL have port rot_sel  out  3  rotation select driving all eight 3-bit 8-to-1 character muxes of the HELLO display.
REQ-011 SHALL have port tick  out  1  one-cycle pulse in the first cycle rot_sel holds a newly advanced value.
REQ-012 SHALL have port running  out  1  1 whenever FSM is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DWELL; all outputs registered.
REQ-014 SHALL transition IDLE->RUN on run=1 and RUN->IDLE or DWELL->IDLE on run=0, evaluated every edge.
REQ-015 SHALL count a prescaler 0..TICK_DIV-1 in RUN only; at TICK_DIV-1 it wraps to 0 and generates one advance.
REQ-016 SHALL clear the prescaler on entry to IDLE, on load, and on DWELL->RUN; run=0 on a terminal-count cycle SHALL suppress that advance.
REQ-017 SHALL compute advance modulo 8: dir=0 rot_sel+1 (7 wraps to 0), dir=1 rot_sel-1 (0 wraps to 7); dir sampled at the advancing edge only.
REQ-018 SHALL pass step through two synchronizer flops plus one history flop; a synchronized rising edge in IDLE SHALL advance once, with rot_sel updating at the 3rd rising edge after step goes high.
REQ-019 SHALL ignore step edges while in RUN or DWELL; a held step SHALL produce exactly one advance.
REQ-020 SHALL give load priority over any advance: rot_sel<=load_val, tick=0, FSM state unchanged except DWELL returns to RUN.
REQ-021 SHALL assert tick for every advance (automatic or step) and for nothing else.

Reset
REQ-022 SHALL on Resetn=0, without a clock edge, force rot_sel=0, tick=0, running=0, state=IDLE, prescaler=0, dwell counter=0, synchronizer and history flops=0.
REQ-023 SHALL resume from reset values on the first rising edge after Resetn deasserts; step held high through reset release SHALL yield one advance if run=0.

Configuration
REQ-024 SHALL, when HELLO_SCROLL_DWELL_EN is defined, enter DWELL whenever an automatic advance lands rot_sel on 0, holding rot_sel for DWELL_TICKS full prescaler periods, then return to RUN with prescaler 0.
REQ-025 SHALL, when HELLO_SCROLL_DWELL_EN is undefined, omit the dwell counter; DWELL SHALL be unreachable and every RUN period TICK_DIV cycles.
REQ-026 SHALL never enter DWELL on step-driven or load-driven arrival at 0 regardless of configuration.

Verification (TICK_DIV=4 unless stated)
REQ-027 SHALL cover: reset, run=1, dir=0 -> rot_sel 0,1,...,7,0 changing every 4 cycles, tick high one cycle per change, running=1.
REQ-028 SHALL cover: rot_sel=0, run=1, dir=1 -> rot_sel=7 after 4 cycles, then 6.
REQ-029 SHALL cover: run=0, rot_sel=2, step high for 5 cycles -> rot_sel=3 at 3rd edge after rise, no further change, one tick.
REQ-030 SHALL cover: load=1, load_val=5 on prescaler terminal-count cycle -> rot_sel=5, tick=0; next advance to 6 exactly 4 cycles later.
REQ-031 SHALL cover: Resetn low mid-run at rot_sel=3 with clock stopped -> rot_sel=0, running=0, tick=0 immediately.
REQ-032 SHALL cover: HELLO_SCROLL_DWELL_EN, DWELL_TICKS=2, dir=0 -> after 7->0, rot_sel holds 0 for 12 cycles before advancing to 1.
